// File: rtl/hit_judge.sv
// hit_judge: judges lane-button presses against the arrow on the hit line, one
// judging window per metronome beat, and keeps score, combo and lives.
// Ports: clk, rst (async active-high), metronome_clk (async beat), state (game
//   state), arrow3 (hit-line arrow), btn (raw buttons, async) ->
//   score, combo, lives, game_over, hit_pulse, miss_pulse.
module hit_judge #(
  parameter int BeginState = 0,
  parameter int ResetState = 2,
  parameter int BLANK      = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        metronome_clk,
  input  logic [1:0]  state,
  input  logic [4:0]  arrow3,
  input  logic [3:0]  btn,
  output logic [13:0] score,
  output logic [6:0]  combo,
  output logic [1:0]  lives,
  output logic        game_over,
  output logic        hit_pulse,
  output logic        miss_pulse
);

  localparam logic [1:0] BEGIN_CODE = BeginState[1:0];
  localparam logic [1:0] RESET_CODE = ResetState[1:0];
  localparam logic [4:0] BLANK_CODE = BLANK[4:0];

  typedef enum logic [1:0] {IDLE, ARMED, DONE} win_t;

  logic [2:0]  met_s;
  logic        beat_tick;
  logic        tick_d1;
  logic        tick_d2;
  logic [3:0]  btn_s1;
  logic [3:0]  btn_s2;
  logic [3:0]  btn_d;
  logic [3:0]  press;
  win_t        win;
  logic [1:0]  target;
  logic        in_begin;
  logic        in_reset;
  logic        active;
  logic        press_any;
  logic        press_ok;
  logic        hit;
  logic        miss;
  logic        arrow_live;
  logic [14:0] score_sum;
  logic [13:0] score_next;
  logic [6:0]  combo_next;
  logic [1:0]  lives_next;

  // Synchronizers and edge detectors. met_s shifts in from the top, so met_s[2]
  // is the metastability stage and ~s[0] & s[1] is a rising edge of the beat.
  // tick_d2 marks the cycle where the arrow buffer's shifted output is stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      met_s     <= '0;
      beat_tick <= 1'b0;
      tick_d1   <= 1'b0;
      tick_d2   <= 1'b0;
      btn_s1    <= '0;
      btn_s2    <= '0;
      btn_d     <= '0;
    end else begin
      met_s     <= {metronome_clk, met_s[2:1]};
      beat_tick <= ~met_s[0] & met_s[1];
      tick_d1   <= beat_tick;
      tick_d2   <= tick_d1;
      btn_s1    <= btn;
      btn_s2    <= btn_s1;
      btn_d     <= btn_s2;
    end
  end

  assign game_over = (lives == 2'd0);

  always_comb begin
    press      = btn_s2 & ~btn_d;
    in_begin   = (state == BEGIN_CODE);
    in_reset   = (state == RESET_CODE);
    active     = in_begin & ~game_over;
    press_any  = |press;
    press_ok   = (press == (4'b0001 << target));
    // A press always decides the window, even when it lands on the closing beat.
    hit        = active && (win == ARMED) && press_any && press_ok;
    miss       = active && (win == ARMED) && (press_any ? !press_ok : beat_tick);
    arrow_live = (arrow3 < 5'd4) && (arrow3 != BLANK_CODE);
    score_sum  = {1'b0, score} + ((combo >= 7'd10) ? 15'd2 : 15'd1);
    score_next = (score_sum >= 15'd9999) ? 14'd9999 : score_sum[13:0];
    combo_next = (combo >= 7'd99) ? 7'd99 : combo + 7'd1;
    lives_next = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score      <= '0;
      combo      <= '0;
      lives      <= 2'd3;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      win        <= IDLE;
      target     <= '0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      if (in_reset) begin
        score <= '0;
        combo <= '0;
        lives <= 2'd3;
        win   <= IDLE;
      end else if (in_begin) begin
        if (game_over) begin
          win <= IDLE;
        end else begin
          hit_pulse  <= hit;
          miss_pulse <= miss;
          if (hit) begin
            score <= score_next;
            combo <= combo_next;
          end
          if (miss) begin
            combo <= '0;
            lives <= lives_next;
          end
          // The closing window is judged above; a new arrow opening in the
          // same cycle replaces it.
          if (tick_d2) begin
            win    <= arrow_live ? ARMED : IDLE;
            target <= arrow3[1:0];
          end else if (hit || miss) begin
            win <= DONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hit_judge.sv
module tb_hit_judge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        metronome_clk = 1'b0;
  logic [1:0]  state = 2'd0;
  logic [4:0]  arrow3 = 5'd20;
  logic [3:0]  btn = 4'd0;
  logic [13:0] score;
  logic [6:0]  combo;
  logic [1:0]  lives;
  logic        game_over;
  logic        hit_pulse;
  logic        miss_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int n_hit    = 0;
  int n_miss   = 0;

  hit_judge dut (
    .clk(clk), .rst(rst), .metronome_clk(metronome_clk), .state(state),
    .arrow3(arrow3), .btn(btn), .score(score), .combo(combo), .lives(lives),
    .game_over(game_over), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: per-edge input history, rules applied directly.
  int       m_score = 0;
  int       m_combo = 0;
  int       m_lives = 3;
  bit       m_hit = 0;
  bit       m_miss = 0;
  bit       m_open = 0;
  int       m_target = 0;
  bit [3:0] h_btn[8];
  bit       h_met[8];
  int       cyc = 0;
  logic [3:0] one4 = 4'b0001;

  function automatic int idx(input int back);
    return (cyc + 8 - back) % 8;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Runs at each falling edge: advance the model for the rising edge just
  // passed (inputs still hold the values that edge sampled), then compare.
  task automatic model_step();
    bit [3:0] pr;
    bit tk, ld;
    cyc++;
    m_hit = 0;
    m_miss = 0;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        h_btn[i] = 0;
        h_met[i] = 0;
      end
      m_score = 0; m_combo = 0; m_lives = 3; m_open = 0;
    end else begin
      h_btn[idx(0)] = btn;
      h_met[idx(0)] = metronome_clk;
      pr = h_btn[idx(2)] & ~h_btn[idx(3)];
      tk = h_met[idx(3)] & ~h_met[idx(4)];
      ld = h_met[idx(5)] & ~h_met[idx(6)];
      if (state == 2'd2) begin
        m_score = 0; m_combo = 0; m_lives = 3; m_open = 0;
      end else if (state == 2'd0) begin
        if (m_lives == 0) begin
          m_open = 0;
        end else begin
          if (m_open) begin
            if (pr != 0) begin
              if ($countones(pr) == 1 && pr[m_target]) m_hit = 1;
              else m_miss = 1;
            end else if (tk) begin
              m_miss = 1;
            end
          end
          if (m_hit) begin
            m_score = m_score + ((m_combo >= 10) ? 2 : 1);
            if (m_score > 9999) m_score = 9999;
            m_combo = (m_combo + 1 > 99) ? 99 : m_combo + 1;
          end
          if (m_miss) begin
            m_combo = 0;
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
          end
          if (ld) begin
            m_open = (arrow3 <= 5'd3);
            m_target = int'(arrow3);
          end else if (m_hit || m_miss) begin
            m_open = 0;
          end
        end
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
    if (hit_pulse === 1'b1) n_hit++;
    if (miss_pulse === 1'b1) n_miss++;
    n_checks++;
    if (score !== 14'(m_score) || combo !== 7'(m_combo) || lives !== 2'(m_lives) ||
        game_over !== (m_lives == 0) || hit_pulse !== m_hit || miss_pulse !== m_miss) begin
      n_fail++;
      $display("FAIL cycle %0d outputs: got score=%0d combo=%0d lives=%0d go=%b hit=%b miss=%b, expected score=%0d combo=%0d lives=%0d go=%b hit=%b miss=%b",
               cyc, score, combo, lives, game_over, hit_pulse, miss_pulse,
               m_score, m_combo, m_lives, (m_lives == 0), m_hit, m_miss);
    end
  end

  task automatic drive(input bit m, input logic [3:0] b, input logic [4:0] a);
    @(negedge clk); #1;
    metronome_clk = m;
    btn = b;
    arrow3 = a;
  endtask

  // One metronome period of 2h cycles; the arrow is held throughout and is
  // latched in this period, press m1 lands inside this window, m2 later in it.
  task automatic window(input int h, input logic [4:0] a, input logic [3:0] m1, input logic [3:0] m2);
    for (int o = 0; o < 2 * h; o++)
      drive(o < h, (o == h + 1) ? m1 : ((o == h + 3) ? m2 : 4'b0000), a);
  endtask

  task automatic blank();
    window(4, 5'd20, 4'b0000, 4'b0000);
  endtask

  task automatic pulse_state2();
    @(negedge clk); #1;
    state = 2'd2; metronome_clk = 1'b0; btn = 4'b0000;
    @(negedge clk); #1;
    state = 2'd0;
  endtask

  task automatic check_now();
    @(negedge clk); #2;
  endtask

  int h0, m0;
  logic [4:0] a;
  logic [4:0] arrows[8] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd20, 5'd4, 5'd31, 5'd7};

  initial begin
    repeat (3) @(negedge clk);
    #2;
    check("reset score", int'(score), 0);
    check("reset combo", int'(combo), 0);
    check("reset lives", int'(lives), 3);
    check("reset game_over", int'(game_over), 0);
    @(negedge clk); #1 rst = 1'b0;
    blank();

    // Correct lane hit.
    h0 = n_hit; m0 = n_miss;
    window(4, 5'd2, 4'b0100, 4'b0000); blank(); check_now();
    check("s1 hits", n_hit - h0, 1);
    check("s1 misses", n_miss - m0, 0);
    check("s1 score", int'(score), 1);
    check("s1 combo", int'(combo), 1);
    check("s1 lives", int'(lives), 3);

    // No press before next beat.
    m0 = n_miss;
    window(4, 5'd1, 4'b0000, 4'b0000); blank(); check_now();
    check("s2 misses", n_miss - m0, 1);
    check("s2 combo", int'(combo), 0);
    check("s2 lives", int'(lives), 2);

    // Correct+wrong together is a miss; a later press in the window is ignored.
    h0 = n_hit; m0 = n_miss;
    window(4, 5'd0, 4'b1001, 4'b0001); blank(); check_now();
    check("s3 hits", n_hit - h0, 0);
    check("s3 misses", n_miss - m0, 1);
    check("s3 lives", int'(lives), 1);

    pulse_state2(); check_now();
    check("clear lives", int'(lives), 3);
    check("clear score", int'(score), 0);

    // Build score 50 with combo 10, then bonus scoring.
    repeat (25) window(4, 5'd1, 4'b0010, 4'b0000);
    window(4, 5'd3, 4'b0000, 4'b0000);
    repeat (10) window(4, 5'd0, 4'b0001, 4'b0000);
    blank(); check_now();
    check("s4 score pre", int'(score), 50);
    check("s4 combo pre", int'(combo), 10);
    check("s4 lives", int'(lives), 2);
    window(4, 5'd2, 4'b0100, 4'b0000); blank(); check_now();
    check("s4 score bonus", int'(score), 52);
    check("s4 combo bonus", int'(combo), 11);

    // Fast beats up to the score ceiling.
    for (int i = 0; i < 4973; i++) begin
      a = 5'($urandom_range(0, 3));
      window(3, a, one4 << a[1:0], 4'b0000);
    end
    blank(); check_now();
    check("sat score 9998", int'(score), 9998);
    check("sat combo 99", int'(combo), 99);
    h0 = n_hit;
    window(3, 5'd1, 4'b0010, 4'b0000); blank(); check_now();
    check("sat score 9999", int'(score), 9999);
    window(3, 5'd3, 4'b1000, 4'b0000); blank(); check_now();
    check("sat score hold", int'(score), 9999);
    check("sat hits", n_hit - h0, 2);

    // Game over and recovery.
    pulse_state2();
    window(4, 5'd2, 4'b0100, 4'b0000);
    repeat (3) window(4, 5'd1, 4'b0000, 4'b0000);
    blank(); check_now();
    check("s5 lives", int'(lives), 0);
    check("s5 game_over", int'(game_over), 1);
    h0 = n_hit; m0 = n_miss;
    repeat (2) window(4, 5'd2, 4'b0100, 4'b0000);
    blank(); check_now();
    check("s5 frozen hits", n_hit - h0, 0);
    check("s5 frozen misses", n_miss - m0, 0);
    check("s5 frozen score", int'(score), 1);
    pulse_state2(); check_now();
    check("s5 lives restored", int'(lives), 3);
    check("s5 game_over clear", int'(game_over), 0);

    // Blank arrow ignores presses; reset mid-window.
    h0 = n_hit; m0 = n_miss;
    window(4, 5'd20, 4'b1111, 4'b1111); blank(); check_now();
    check("s6 blank hits", n_hit - h0, 0);
    check("s6 blank misses", n_miss - m0, 0);
    window(4, 5'd1, 4'b0010, 4'b0000);
    for (int o = 0; o < 7; o++) drive(o < 4, 4'b0000, 5'd3);
    #1 rst = 1'b1;
    #1;
    check("rst score", int'(score), 0);
    check("rst combo", int'(combo), 0);
    check("rst lives", int'(lives), 3);
    check("rst game_over", int'(game_over), 0);
    check("rst hit_pulse", int'(hit_pulse), 0);
    check("rst miss_pulse", int'(miss_pulse), 0);
    m0 = n_miss;
    drive(0, 4'b0000, 5'd3);
    drive(0, 4'b0000, 5'd3);
    @(negedge clk); #1 rst = 1'b0;
    blank(); blank(); check_now();
    check("s6 no miss after reset", n_miss - m0, 0);
    check("s6 lives after reset", int'(lives), 3);

    // Randomized traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk); #1;
      if ($urandom_range(0, 2) == 0) metronome_clk = ~metronome_clk;
      case ($urandom_range(0, 7))
        0: btn = 4'($urandom);
        1: btn = one4 << m_target;
        default: btn = 4'b0000;
      endcase
      if ($urandom_range(0, 5) == 0) arrows_pick();
      case ($urandom_range(0, 299))
        0, 1: state = 2'd2;
        2: state = 2'd1;
        3: state = 2'd3;
        default: if ($urandom_range(0, 19) == 0) state = 2'd0;
      endcase
      if ($urandom_range(0, 799) == 0) begin
        #1 rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
      end
    end
    blank(); check_now();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic arrows_pick();
    arrow3 = arrows[$urandom_range(0, 7)];
  endtask

endmodule

// File: doc/hit_judge.md
HIT_JUDGE -- requirements
Module: hit_judge

Interface
REQ-001 SHALL have parameter BeginState, default 0, meaning state code in which judging runs.
REQ-002 SHALL have parameter ResetState, default 2, meaning state code that synchronously clears all score state.
REQ-003 SHALL have parameter BLANK, default 20, meaning arrow code for an empty lane slot.
REQ-004 SHALL have port clk  input  1  system clock; all flops rise on posedge clk.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port metronome_clk  input  1  beat clock, asynchronous to clk.
REQ-007 SHALL have port state  input  2  game state code.
REQ-008 SHALL have port arrow3  input  5  bottom (hit-line) arrow from the arrow buffer; codes 0..3 = lanes 0..3, all other codes are blank.
REQ-009 SHALL have port btn  input  4  raw lane buttons, active-high, asynchronous.
REQ-010 SHALL have port score  output  14  binary score.
REQ-011 SHALL have port combo  output  7  consecutive-hit count.
REQ-012 SHALL have port lives  output  2  remaining lives.
REQ-013 SHALL have port game_over  output  1  high when lives is 0.
REQ-014 SHALL have port hit_pulse  output  1  one-cycle pulse per hit.
REQ-015 SHALL have port miss_pulse  output  1  one-cycle pulse per miss.

Function
REQ-016 SHALL form beat_tick as follows: shift metronome_clk into a 3-bit register each cycle; register ~s[0] & s[1]. This matches the arrow buffer's edge detector, so beat_tick is high in the same cycle as its shift-enable.
REQ-017 SHALL pass btn through a 2-flop synchronizer and then a rising-edge detector, producing press[3:0] one-cycle pulses.
REQ-018 SHALL latch target = arrow3 two cycles after beat_tick, when the shifted arrow is stable. A latched value of 0..3 enters ARMED; any other value enters IDLE.
REQ-019 SHALL implement the window FSM with states IDLE, ARMED and DONE.
  - ARMED + press of only the target lane -> hit, go to DONE.
  - ARMED + any press including a non-target lane (also simultaneous correct+wrong) -> miss, go to DONE.
  - ARMED + beat_tick with no press -> miss.
  - IDLE/DONE + press -> ignored.
REQ-020 SHALL evaluate a press coinciding with beat_tick against the closing window before the window closes; that window produces at most one hit or miss.
REQ-021 SHALL make every hit or miss produce exactly one hit_pulse or miss_pulse, registered, in the cycle after the deciding event.
REQ-022 SHALL update counters on a hit as follows:
  - score += 2 if combo >= 10 before the hit, else score += 1;
  - score saturates at 9999;
  - combo += 1, saturating at 99.
REQ-023 SHALL update counters on a miss as follows:
  - combo <= 0;
  - lives <= lives - 1; never below 0.
REQ-024 SHALL hold game_over = (lives == 0) combinationally from the lives register.
REQ-025 SHALL, while game_over is high, hold the FSM in IDLE, generate no pulses and keep counters frozen.
REQ-026 SHALL, when state == ResetState, synchronously set score=0, combo=0, lives=3 and FSM=IDLE, with pulses low.
REQ-027 SHALL, when state is neither BeginState nor ResetState, freeze the FSM and all counters and ignore presses; synchronizers keep running.

Reset
REQ-028 SHALL, while rst is high, immediately force score=0, combo=0, lives=3, game_over=0, hit_pulse=0, miss_pulse=0, FSM=IDLE, and clear all synchronizer and edge flops.
REQ-029 SHALL discard any open window when rst asserts mid-window, and SHALL NOT produce a pulse on release.
REQ-030 SHALL resume operation on the first beat_tick after rst deasserts.

Verification
REQ-031 SHALL pass this scenario: arrow3=2 latched, then btn[2] rises -> hit_pulse once, score 0->1, combo 0->1, lives stays 3.
REQ-032 SHALL pass this scenario: arrow3=1 latched, no press before next beat_tick -> miss_pulse once, combo cleared, lives 3->2.
REQ-033 SHALL pass this scenario: arrow3=0 latched, btn[0] and btn[3] rise in the same cycle -> miss (not hit); a later btn[0] in the same window -> no pulse.
REQ-034 SHALL pass this scenario: combo=10, score=50, correct press -> score=52, combo=11; score=9998 with bonus hit -> score=9999.
REQ-035 SHALL pass this scenario: three consecutive misses -> lives=0, game_over=1; further correct presses -> no pulses, score unchanged; state=2 for one cycle -> lives=3, game_over=0.
REQ-036 SHALL pass this scenario: arrow3=20 latched, presses on all lanes -> no pulses; rst asserted mid-ARMED window -> outputs at reset values within the same cycle, no miss on release.
